// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master (START, address+R/W, one data byte, STOP).
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL by holding it low.
module i2c_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       ready,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_ADDR      = 4'd2,
    ST_ADDR_ACK  = 4'd3,
    ST_WRITE     = 4'd4,
    ST_WRITE_ACK = 4'd5,
    ST_READ      = 4'd6,
    ST_READ_ACK  = 4'd7,
    ST_STOP      = 4'd8
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_r, next_state_s;
  logic [7:0] div_cnt_r;
  logic [1:0] q_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] addr_r;
  logic       rw_r;
  logic [7:0] wdata_r;
  logic [7:0] rx_shift_r;
  logic [7:0] data_out_r;
  logic       ready_r;
  logic       nack_r;
  logic       sda_low_r, scl_low_r;
  logic       sda_low_s, scl_low_s;
  logic       stall_s, tick_s, sample_s, bit_end_s, last_bit_s, accept_s;
  logic [7:0] addr_byte_s;

`ifdef I2C_CLK_STRETCH_EN
  assign stall_s = (state_r != ST_IDLE) && !scl_low_r && !i2c_scl;
`else
  assign stall_s = 1'b0;
`endif

  assign addr_byte_s = {addr_r, rw_r};
  assign tick_s      = (div_cnt_r == DIV_LAST) && !stall_s;
  assign sample_s    = tick_s && (q_r == 2'd2);
  assign bit_end_s   = tick_s && (q_r == 2'd3);
  assign last_bit_s  = (bit_cnt_r == 3'd7);
  assign accept_s    = (state_r == ST_IDLE) && ready_r && enable;

  // Open-drain pads: only ever pull low or release.
  assign i2c_sda  = sda_low_r ? 1'b0 : 1'bz;
  assign i2c_scl  = scl_low_r ? 1'b0 : 1'bz;
  assign data_out = data_out_r;
  assign ready    = ready_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Quarter-tick divider, quarter index and bit index within the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= 8'd0;
      q_r       <= 2'd0;
      bit_cnt_r <= 3'd0;
    end else if (state_r == ST_IDLE) begin
      div_cnt_r <= 8'd0;
      q_r       <= 2'd0;
      bit_cnt_r <= 3'd0;
    end else if (stall_s) begin
      div_cnt_r <= div_cnt_r;
      q_r       <= q_r;
      bit_cnt_r <= bit_cnt_r;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= 8'd0;
      q_r       <= q_r + 2'd1;
      if (q_r == 2'd3) begin
        bit_cnt_r <= (next_state_s != state_r) ? 3'd0 : bit_cnt_r + 3'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end else begin
      div_cnt_r <= div_cnt_r + 8'd1;
      q_r       <= q_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Next-state logic; every transition happens at the end of a bit period.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:      next_state_s = accept_s ? ST_START : ST_IDLE;
      ST_START:     next_state_s = bit_end_s ? ST_ADDR : ST_START;
      ST_ADDR:      next_state_s = (bit_end_s && last_bit_s) ? ST_ADDR_ACK : ST_ADDR;
      ST_ADDR_ACK: begin
        if (bit_end_s) begin
          next_state_s = nack_r ? ST_STOP : (rw_r ? ST_READ : ST_WRITE);
        end else begin
          next_state_s = ST_ADDR_ACK;
        end
      end
      ST_WRITE:     next_state_s = (bit_end_s && last_bit_s) ? ST_WRITE_ACK : ST_WRITE;
      ST_WRITE_ACK: next_state_s = bit_end_s ? ST_STOP : ST_WRITE_ACK;
      ST_READ:      next_state_s = (bit_end_s && last_bit_s) ? ST_READ_ACK : ST_READ;
      ST_READ_ACK:  next_state_s = bit_end_s ? ST_STOP : ST_READ_ACK;
      ST_STOP:      next_state_s = bit_end_s ? ST_IDLE : ST_STOP;
      default:      next_state_s = ST_IDLE;
    endcase
  end

  // Line levels per state and quarter; ACK and read bits leave SDA to the slave.
  always_comb begin
    scl_low_s = (q_r < 2'd2);
    sda_low_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        scl_low_s = 1'b0;
        sda_low_s = 1'b0;
      end
      ST_START: begin
        scl_low_s = (q_r == 2'd3);
        sda_low_s = (q_r >= 2'd2);
      end
      ST_ADDR:  sda_low_s = !addr_byte_s[3'd7 - bit_cnt_r];
      ST_WRITE: sda_low_s = !wdata_r[3'd7 - bit_cnt_r];
      ST_STOP:  sda_low_s = (q_r != 2'd3);
      default:  sda_low_s = 1'b0;
    endcase
  end

  // Registered pad enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sda_low_r <= 1'b0;
      scl_low_r <= 1'b0;
    end else begin
      sda_low_r <= sda_low_s;
      scl_low_r <= scl_low_s;
    end
  end

  // Request latch, ACK sample, read shifter and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r     <= 7'd0;
      rw_r       <= 1'b0;
      wdata_r    <= 8'd0;
      nack_r     <= 1'b0;
      rx_shift_r <= 8'd0;
      data_out_r <= 8'd0;
    end else begin
      if (accept_s) begin
        addr_r  <= addr;
        rw_r    <= rw;
        wdata_r <= data_in;
      end else begin
        addr_r  <= addr_r;
        rw_r    <= rw_r;
        wdata_r <= wdata_r;
      end
      if (sample_s && (state_r == ST_ADDR_ACK)) begin
        nack_r <= i2c_sda;
      end else begin
        nack_r <= nack_r;
      end
      if (sample_s && (state_r == ST_READ)) begin
        rx_shift_r <= {rx_shift_r[6:0], i2c_sda};
      end else begin
        rx_shift_r <= rx_shift_r;
      end
      if (bit_end_s && (state_r == ST_READ) && last_bit_s) begin
        data_out_r <= rx_shift_r;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  // Ready follows the state the machine is entering, so it rises on the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= (next_state_s == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
// Bench for i2c_master: behavioural slave at 7'h2A (ACKs, returns 8'hCD) and a transfer-level model.
module tb_i2c_master;
  localparam int DIV = 3;
  localparam int BIT_CLKS = 4 * DIV;
  localparam logic [6:0] SLV_ADDR = 7'h2A;
  localparam logic [7:0] SLV_RDATA = 8'hCD;
  localparam int P_ADDR = 0, P_AACK = 1, P_WR = 2, P_WACK = 3, P_RD = 4, P_RACK = 5, P_IDLE = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] data_in = 8'd0;
  logic       enable = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] data_out;
  logic       ready;
  wire        i2c_sda, i2c_scl;

  logic slv_sda_low = 1'b0;
  logic slv_scl_low = 1'b0;

  pullup pu_sda (i2c_sda);
  pullup pu_scl (i2c_scl);
  assign i2c_sda = slv_sda_low ? 1'b0 : 1'bz;
  assign i2c_scl = slv_scl_low ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .enable(enable), .rw(rw),
    .data_out(data_out), .ready(ready), .i2c_sda(i2c_sda), .i2c_scl(i2c_scl)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fails = 0;
  logic [7:0] model_dout = 8'h00;

  // Slave model state, observed by the tests.
  int         s_phase = P_IDLE;
  int         s_bits = 0;
  int         s_starts = 0;
  int         s_stops = 0;
  int         hold_cnt = 0;
  logic [7:0] s_shift = 8'h00;
  logic [7:0] s_addr_byte = 8'h00;
  logic [7:0] s_wr_byte = 8'h00;
  logic       s_read = 1'b0;
  logic       s_master_ack = 1'b0;
  logic       stretch_arm = 1'b0;

  initial begin : slave_model
    logic cur_scl, cur_sda, prev_scl, prev_sda;
    logic [7:0] rd_byte;
    rd_byte = SLV_RDATA;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cur_scl = i2c_scl;
      cur_sda = i2c_sda;
      if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
        s_starts++;
        s_phase = P_ADDR;
        s_bits = 0;
        slv_sda_low = 1'b0;
      end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
        s_stops++;
        s_phase = P_IDLE;
        slv_sda_low = 1'b0;
      end else if (!prev_scl && cur_scl) begin
        if (s_phase == P_ADDR || s_phase == P_WR || s_phase == P_RD) begin
          s_shift = {s_shift[6:0], cur_sda};
          s_bits++;
        end else if (s_phase == P_RACK) begin
          s_master_ack = cur_sda;
        end
      end else if (prev_scl && !cur_scl) begin
        case (s_phase)
          P_ADDR: begin
            if (s_bits == 8) begin
              s_addr_byte = s_shift;
              s_bits = 0;
              if (s_shift[7:1] == SLV_ADDR) begin
                slv_sda_low = 1'b1;
                s_read = s_shift[0];
                s_phase = P_AACK;
              end else begin
                s_phase = P_IDLE;
              end
            end else if (s_bits == 3 && stretch_arm) begin
              stretch_arm = 1'b0;
              slv_scl_low = 1'b1;
              hold_cnt = 2 * DIV + 11;
            end
          end
          P_AACK: begin
            s_bits = 0;
            if (s_read) begin
              s_phase = P_RD;
              slv_sda_low = !rd_byte[7];
            end else begin
              s_phase = P_WR;
              slv_sda_low = 1'b0;
            end
          end
          P_WR: begin
            if (s_bits == 8) begin
              s_wr_byte = s_shift;
              slv_sda_low = 1'b1;
              s_phase = P_WACK;
            end
          end
          P_WACK: begin
            slv_sda_low = 1'b0;
            s_phase = P_IDLE;
          end
          P_RD: begin
            if (s_bits == 8) begin
              slv_sda_low = 1'b0;
              s_phase = P_RACK;
            end else begin
              slv_sda_low = !rd_byte[7 - s_bits];
            end
          end
          P_RACK: s_phase = P_IDLE;
          default: s_phase = P_IDLE;
        endcase
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) slv_scl_low = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference length of a transfer in system clocks, from the bit-count rule.
  function automatic int exp_clocks(input logic [6:0] a);
    return ((a == SLV_ADDR) ? 20 : 11) * BIT_CLKS;
  endfunction

  // Issue one request and count clocks until ready returns (bounded).
  task automatic do_transfer(input logic [6:0] a, input logic r, input logic [7:0] d, output int clks);
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fails++;
      $display("FAIL ready_before_req: ready=%b, expected 1", ready);
    end
    addr = a; rw = r; data_in = d; enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    addr = 7'($urandom); rw = 1'($urandom); data_in = 8'($urandom);
    n_tests++;
    if (ready !== 1'b0) begin
      n_fails++;
      $display("FAIL ready_after_accept: ready=%b, expected 0", ready);
    end
    clks = 0;
    while (ready !== 1'b1 && clks < 40 * BIT_CLKS) begin
      @(posedge clk);
      #1;
      clks++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b0 || data_out !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_outputs: ready=%b data_out=%h, expected 0 and 00", ready, data_out);
    end
    n_tests++;
    if (i2c_sda !== 1'b1 || i2c_scl !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_lines: sda=%b scl=%b, expected 1 1", i2c_sda, i2c_scl);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (ready !== 1'b0) begin
      n_fails++;
      $display("FAIL ready_before_edge: ready=%b, expected 0", ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b1) begin
      n_fails++;
      $display("FAIL ready_first_edge: ready=%b, expected 1", ready);
    end
  endtask

  task automatic test_read();
    int clks, st0, sp0;
    st0 = s_starts; sp0 = s_stops; s_master_ack = 1'b0;
    do_transfer(SLV_ADDR, 1'b1, 8'h00, clks);
    model_dout = SLV_RDATA;
    n_tests++;
    if (clks != 20 * BIT_CLKS) begin
      n_fails++;
      $display("FAIL read_len: got %0d clocks, expected %0d", clks, 20 * BIT_CLKS);
    end
    n_tests++;
    if (data_out !== model_dout) begin
      n_fails++;
      $display("FAIL read_data: data_out=%h, expected %h", data_out, model_dout);
    end
    n_tests++;
    if (s_addr_byte !== 8'h55) begin
      n_fails++;
      $display("FAIL read_addr_byte: got %h, expected 55", s_addr_byte);
    end
    n_tests++;
    if (s_master_ack !== 1'b1) begin
      n_fails++;
      $display("FAIL read_nack: master ack bit=%b, expected 1", s_master_ack);
    end
    n_tests++;
    if (s_starts - st0 != 1 || s_stops - sp0 != 1) begin
      n_fails++;
      $display("FAIL read_start_stop: starts=%0d stops=%0d, expected 1 1", s_starts - st0, s_stops - sp0);
    end
    n_tests++;
    if (i2c_sda !== 1'b1 || i2c_scl !== 1'b1) begin
      n_fails++;
      $display("FAIL idle_lines: sda=%b scl=%b, expected 1 1", i2c_sda, i2c_scl);
    end
  endtask

  task automatic test_write();
    int clks;
    s_wr_byte = 8'h00;
    do_transfer(SLV_ADDR, 1'b0, 8'hAA, clks);
    n_tests++;
    if (clks != 20 * BIT_CLKS) begin
      n_fails++;
      $display("FAIL write_len: got %0d clocks, expected %0d", clks, 20 * BIT_CLKS);
    end
    n_tests++;
    if (s_addr_byte !== 8'h54 || s_wr_byte !== 8'hAA) begin
      n_fails++;
      $display("FAIL write_bytes: addr=%h data=%h, expected 54 AA", s_addr_byte, s_wr_byte);
    end
    n_tests++;
    if (data_out !== model_dout) begin
      n_fails++;
      $display("FAIL write_hold_dout: data_out=%h, expected %h", data_out, model_dout);
    end
  endtask

  task automatic test_nack();
    int clks, sp0;
    sp0 = s_stops;
    do_transfer(7'h11, 1'b1, 8'h00, clks);
    n_tests++;
    if (clks != 11 * BIT_CLKS) begin
      n_fails++;
      $display("FAIL nack_len: got %0d clocks, expected %0d", clks, 11 * BIT_CLKS);
    end
    n_tests++;
    if (data_out !== model_dout || s_stops - sp0 != 1) begin
      n_fails++;
      $display("FAIL nack_dout_stop: data_out=%h stops=%0d, expected %h 1", data_out, s_stops - sp0, model_dout);
    end
  endtask

  task automatic test_random();
    int clks;
    logic [6:0] a;
    logic r, hit;
    logic [7:0] d, exp_wr;
    for (int i = 0; i < 8; i++) begin
      hit = ($urandom_range(0, 2) != 0);
      a = hit ? SLV_ADDR : 7'($urandom);
      if (!hit && a == SLV_ADDR) a = 7'h2B;
      r = 1'($urandom);
      d = 8'($urandom);
      s_wr_byte = 8'h00;
      s_addr_byte = 8'h00;
      do_transfer(a, r, d, clks);
      if (hit && r) model_dout = SLV_RDATA;
      exp_wr = (hit && !r) ? d : 8'h00;
      n_tests++;
      if (clks != exp_clocks(a)) begin
        n_fails++;
        $display("FAIL rand_len[%0d]: got %0d clocks, expected %0d", i, clks, exp_clocks(a));
      end
      n_tests++;
      if (data_out !== model_dout || s_addr_byte !== {a, r} || s_wr_byte !== exp_wr) begin
        n_fails++;
        $display("FAIL rand_data[%0d]: dout=%h addr=%h wr=%h, expected %h %h %h",
                 i, data_out, s_addr_byte, s_wr_byte, model_dout, {a, r}, exp_wr);
      end
    end
  endtask

  task automatic test_reset_mid();
    int sp0;
    sp0 = s_stops;
    @(negedge clk);
    addr = SLV_ADDR; rw = 1'b0; data_in = 8'hAA; enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (12 * BIT_CLKS + 2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_dout = 8'h00;
    n_tests++;
    if (i2c_sda !== 1'b1 || i2c_scl !== 1'b1 || data_out !== model_dout || ready !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_async: sda=%b scl=%b dout=%h ready=%b, expected 1 1 00 0",
               i2c_sda, i2c_scl, data_out, ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b1) begin
      n_fails++;
      $display("FAIL abort_ready: ready=%b, expected 1", ready);
    end
    @(negedge clk);
    n_tests++;
    if (s_stops != sp0) begin
      n_fails++;
      $display("FAIL abort_no_stop: stops=%0d, expected %0d", s_stops, sp0);
    end
  endtask

  task automatic test_back_to_back();
    int clks;
    s_wr_byte = 8'h00;
    do_transfer(SLV_ADDR, 1'b0, 8'h3C, clks);
    n_tests++;
    if (clks != 20 * BIT_CLKS || s_wr_byte !== 8'h3C || data_out !== model_dout) begin
      n_fails++;
      $display("FAIL b2b_write: clks=%0d wr=%h dout=%h, expected %0d 3C %h",
               clks, s_wr_byte, data_out, 20 * BIT_CLKS, model_dout);
    end
    do_transfer(SLV_ADDR, 1'b1, 8'h00, clks);
    model_dout = SLV_RDATA;
    n_tests++;
    if (clks != 20 * BIT_CLKS || data_out !== model_dout) begin
      n_fails++;
      $display("FAIL b2b_read: clks=%0d dout=%h, expected %0d %h", clks, data_out, 20 * BIT_CLKS, model_dout);
    end
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    int clks;
    stretch_arm = 1'b1;
    do_transfer(SLV_ADDR, 1'b1, 8'h00, clks);
    model_dout = SLV_RDATA;
    n_tests++;
    if (clks != 20 * BIT_CLKS + 10 || data_out !== model_dout || stretch_arm !== 1'b0) begin
      n_fails++;
      $display("FAIL stretch: clks=%0d dout=%h armed=%b, expected %0d %h 0",
               clks, data_out, stretch_arm, 20 * BIT_CLKS + 10, model_dout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_nack();
    test_random();
    test_reset_mid();
    test_back_to_back();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
